proc_scheduler: RTL
===================

Name: proc_scheduler

Overview:
- Sits between cmd_parser's proc_* port and NUM_LANES char_buff/md5 lanes, so several md5 engines search one PROC batch in parallel.
- Splits each batch into NUM_LANES contiguous segments, overlapping by one match-string length minus one, and steers each received byte to every lane whose segment contains it.
- Collects per-lane done/match results and presents one aggregated result to cmd_parser.
- Routes match-string readback to the winning lane, with the byte position rebased to the batch origin.

Parameters:
- NUM_LANES, 4, number of downstream lanes; power of 2, range 1..16.
- LANE_LOG2, 2, log2(NUM_LANES).
- TIMEOUT_CYCLES, 65535, watchdog limit; used only with PROC_SCHED_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- proc_start  in  1  one-cycle batch start from cmd_parser.
- proc_num_bytes  in  16  batch length; sampled on proc_start.
- proc_str_len  in  16  match length in bits; sampled on proc_start.
- proc_data  in  8  batch byte.
- proc_data_valid  in  1  proc_data qualifier.
- proc_match_char_next  in  1  advance readback character.
- proc_done  out  1  one-cycle aggregated completion.
- proc_match  out  1  any lane matched; held until the next proc_start.
- proc_byte_pos  out  16  rebased match position; held until the next proc_start.
- proc_match_char  out  8  current character of the selected lane.
- lane_start  out  NUM_LANES  per-lane start pulse.
- lane_num_bytes  out  16*NUM_LANES  per-lane length; lane k is at [16k+15:16k].
- lane_data  out  8  registered byte, broadcast to all lanes.
- lane_data_valid  out  NUM_LANES  per-lane byte qualifier.
- lane_done  in  NUM_LANES  per-lane done pulse.
- lane_match  in  NUM_LANES  per-lane match; valid with lane_done.
- lane_byte_pos  in  16*NUM_LANES  lane-relative position; valid with lane_done.
- lane_match_char  in  8*NUM_LANES  per-lane readback character.
- lane_match_char_next  out  NUM_LANES  readback advance; only the selected lane's bit is ever driven.
- busy  out  1  high from the cycle after proc_start until proc_done.

Behaviour:
- Reset: all outputs are 0, all registers are cleared, and state is IDLE.
  - Reset is asynchronous; asserting it mid-batch aborts the batch with no proc_done.
- Segment arithmetic, computed on the proc_start cycle and registered:
  - N = proc_num_bytes; seg = (N + NUM_LANES - 1) >> LANE_LOG2; ovl = (proc_str_len >> 3) - 1, saturating at 0.
  - base_k = k*seg; end_k = min(base_k + seg + ovl, N).
  - lane_num_bytes_k = end_k - base_k when base_k < N, otherwise 0.
  - All arithmetic is 17-bit internally so it cannot overflow.
- States:
  - IDLE: on proc_start go to STREAM, pulse lane_start[k] in cycle T+1 for every lane with a nonzero length, and preset done_seen[k] = 1 for zero-length lanes.
  - STREAM: byte index idx starts at 0.
    - For each proc_data_valid, register lane_data = proc_data and set lane_data_valid[k] = (base_k <= idx < end_k), giving one cycle of latency; then increment idx.
    - A byte received at T+1 reaches the lanes at T+2, after lane_start.
    - Go to WAIT_DONE when idx == N. N = 0 goes directly to WAIT_DONE.
  - WAIT_DONE: on lane_done[k], latch sticky done_seen[k], match_k and pos_k.
    - When all done_seen bits are set, select sel = the lowest k with match_k, then go to REPORT.
  - REPORT: pulse proc_done for one cycle with:
    - proc_match = OR of all match_k;
    - proc_byte_pos = pos_sel + base_sel, or 0 when there is no match.
    - Then go to HOLD.
  - HOLD:
    - proc_match_char = lane_match_char[sel], combinational.
    - proc_match_char_next is forwarded combinationally to lane_match_char_next[sel] only.
    - With no match, proc_match_char = 0 and proc_match_char_next is ignored.
    - proc_start returns the block to the IDLE flow.
- Boundary conditions:
  - proc_start in any non-IDLE state aborts the current batch and restarts; lanes receive a fresh lane_start.
  - lane_done arriving on the same cycle as the last byte is accepted.
  - A duplicate lane_done is ignored.
  - A lane_done from a lane with done_seen already set is ignored.
  - proc_data_valid outside STREAM is dropped.

Optional Feature:
- Macro: PROC_SCHED_TIMEOUT_EN.
- When defined:
  - A 16-bit counter runs in STREAM and WAIT_DONE.
  - On reaching TIMEOUT_CYCLES the block goes to REPORT with proc_match = 0 and proc_byte_pos = 0.
  - Extra output port timeout (1 bit) is set at that point and cleared on the next proc_start.
- When not defined: the counter and the port are absent, and the block waits indefinitely.

Decomposition:
- Package proc_sched_pkg holds:
  - state encodings IDLE = 0, STREAM = 1, WAIT_DONE = 2, REPORT = 3, HOLD = 4;
  - the 16-bit position width constant;
  - the bits-to-chars shift constant, 3.
- One natural sub-module, lane_window: per-lane base/end registers, the range compare that produces lane_data_valid[k], and the done/match/pos capture. It is instantiated NUM_LANES times.

Test Plan (NUM_LANES = 4, proc_str_len = 0x98, so ovl = 18):
- N = 100 -> lane_num_bytes = 43, 43, 43, 25; lane2 receives idx 50..92 exactly; lane_start pulses at T+1.
- N = 100, only lane2 matches with pos 7 -> proc_match = 1, proc_byte_pos = 57; 19 proc_match_char_next pulses reach lane2 only.
- N = 100, lanes 1 and 3 match (pos 3 and 2) -> sel = 1, proc_byte_pos = 28.
- N = 3 -> lengths 3, 2, 1, 0; lane3 gets no start; proc_done follows the third lane's done.
- proc_start in mid-STREAM after 10 bytes -> restart; new lane_starts; old partial results discarded.
- reset low during WAIT_DONE -> all outputs 0 immediately; no proc_done. With PROC_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES = 200 and a stalled lane: proc_done with match 0 and timeout = 1.

Source files
------------

// File: rtl/proc_sched_pkg.sv
// Shared definitions for proc_scheduler: FSM state encoding, the position
// width and the bits-to-characters shift used to derive segment overlap.
package proc_sched_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        STREAM    = 3'd1,
        WAIT_DONE = 3'd2,
        REPORT    = 3'd3,
        HOLD      = 3'd4
    } sched_state_e;

    localparam int unsigned POS_W      = 16;
    localparam int unsigned CHAR_SHIFT = 3;

    // Overlap between adjacent segments: match length in characters minus
    // one, saturating at zero.
    function automatic logic [16:0] overlap_len(input logic [POS_W-1:0] str_len_bits);
        logic [16:0] chars;
        chars = 17'(str_len_bits >> CHAR_SHIFT);
        return (chars == 17'd0) ? 17'd0 : chars - 17'd1;
    endfunction

endpackage

// File: rtl/proc_scheduler_if.sv
// cmd_parser-side PROC port of proc_scheduler.
//   master : cmd_parser (drives start/length/data/readback advance)
//   slave  : proc_scheduler (returns done/match/position/readback char)
interface proc_scheduler_if;
    import proc_sched_pkg::*;

    logic             proc_start;
    logic [POS_W-1:0] proc_num_bytes;
    logic [POS_W-1:0] proc_str_len;
    logic [7:0]       proc_data;
    logic             proc_data_valid;
    logic             proc_match_char_next;
    logic             proc_done;
    logic             proc_match;
    logic [POS_W-1:0] proc_byte_pos;
    logic [7:0]       proc_match_char;

    modport master (
        output proc_start, proc_num_bytes, proc_str_len, proc_data,
               proc_data_valid, proc_match_char_next,
        input  proc_done, proc_match, proc_byte_pos, proc_match_char
    );

    modport slave (
        input  proc_start, proc_num_bytes, proc_str_len, proc_data,
               proc_data_valid, proc_match_char_next,
        output proc_done, proc_match, proc_byte_pos, proc_match_char
    );

endinterface

// File: rtl/proc_scheduler_lane_window.sv
// lane_window: one lane's segment of a PROC batch.
//   start          : batch start; latches base/end/length from n/seg/ovl
//   n, seg, ovl    : batch length, segment size, overlap (valid with start)
//   idx/byte_valid : index of the byte being accepted this cycle
//   capture_en     : lane results may be captured (STREAM/WAIT_DONE)
//   done_in/...    : lane done pulse with match and lane-relative position
//   lane_start     : registered start pulse (only for nonzero length)
//   lane_num_bytes : registered lane length
//   lane_data_valid: registered per-byte qualifier for this lane
//   done_seen/match/pos/base : captured results and segment origin
module lane_window
    import proc_sched_pkg::*;
#(
    parameter int unsigned LANE_IDX = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [16:0]      n,
    input  logic [16:0]      seg,
    input  logic [16:0]      ovl,
    input  logic [16:0]      idx,
    input  logic             byte_valid,
    input  logic             capture_en,
    input  logic             done_in,
    input  logic             match_in,
    input  logic [POS_W-1:0] pos_in,
    output logic             lane_start,
    output logic [POS_W-1:0] lane_num_bytes,
    output logic             lane_data_valid,
    output logic             done_seen,
    output logic             match,
    output logic [POS_W-1:0] pos,
    output logic [POS_W-1:0] base
);

    logic [16:0] base_next, end_sum, end_next, len_next;
    logic [16:0] base_q, end_q;

    always_comb begin
        base_next = 17'(LANE_IDX) * seg;
        end_sum   = base_next + seg + ovl;
        end_next  = (end_sum > n) ? n : end_sum;
        len_next  = (base_next < n) ? (end_next - base_next) : 17'd0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            base_q          <= '0;
            end_q           <= '0;
            lane_num_bytes  <= '0;
            lane_start      <= 1'b0;
            lane_data_valid <= 1'b0;
            done_seen       <= 1'b0;
            match           <= 1'b0;
            pos             <= '0;
        end else if (start) begin
            base_q          <= base_next;
            end_q           <= end_next;
            lane_num_bytes  <= len_next[POS_W-1:0];
            lane_start      <= (len_next != 17'd0);
            lane_data_valid <= 1'b0;
            // Empty lanes never report, so treat them as already done.
            done_seen       <= (len_next == 17'd0);
            match           <= 1'b0;
            pos             <= '0;
        end else begin
            lane_start      <= 1'b0;
            lane_data_valid <= byte_valid && (idx >= base_q) && (idx < end_q);
            if (capture_en && done_in && !done_seen) begin
                done_seen <= 1'b1;
                match     <= match_in;
                pos       <= pos_in;
            end
        end
    end

    assign base = base_q[POS_W-1:0];

endmodule

// File: rtl/proc_scheduler.sv
// proc_scheduler: splits one PROC batch from cmd_parser across NUM_LANES
// char_buff/md5 lanes (overlapping segments), aggregates the per-lane
// results, and routes match-string readback to the winning lane.
//   clk, reset (async, active low)
//   pif        : cmd_parser PROC port (slave side)
//   lane_*     : per-lane start/length/data/valid out, done/match/pos/char in
//   busy       : batch in progress
// Optional: `define PROC_SCHED_TIMEOUT_EN adds a watchdog of TIMEOUT_CYCLES
// cycles and the extra output port timeout.
module proc_scheduler
    import proc_sched_pkg::*;
#(
    parameter int unsigned NUM_LANES      = 4,
    parameter int unsigned LANE_LOG2      = 2,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                       clk,
    input  logic                       reset,
    proc_scheduler_if.slave            pif,
    output logic [NUM_LANES-1:0]       lane_start,
    output logic [16*NUM_LANES-1:0]    lane_num_bytes,
    output logic [7:0]                 lane_data,
    output logic [NUM_LANES-1:0]       lane_data_valid,
    input  logic [NUM_LANES-1:0]       lane_done,
    input  logic [NUM_LANES-1:0]       lane_match,
    input  logic [16*NUM_LANES-1:0]    lane_byte_pos,
    input  logic [8*NUM_LANES-1:0]     lane_match_char,
    output logic [NUM_LANES-1:0]       lane_match_char_next,
    output logic                       busy
`ifdef PROC_SCHED_TIMEOUT_EN
    ,
    output logic                       timeout
`endif
);

    localparam int unsigned SEL_W = (LANE_LOG2 > 0) ? LANE_LOG2 : 1;

    sched_state_e state_q, state_d;

    logic [16:0]      n_d, seg_d, ovl_d;
    logic [16:0]      n_q, idx_q;
    logic             byte_valid, capture_en, to_hit;
    logic             match_q;
    logic [POS_W-1:0] pos_q;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             any_match;

    logic [NUM_LANES-1:0] done_seen_v, match_v;
    logic [POS_W-1:0]     pos_v  [NUM_LANES];
    logic [POS_W-1:0]     base_v [NUM_LANES];

    assign n_d   = 17'(pif.proc_num_bytes);
    assign seg_d = (n_d + 17'(NUM_LANES - 1)) >> LANE_LOG2;
    assign ovl_d = overlap_len(pif.proc_str_len);

    assign byte_valid = (state_q == STREAM) && pif.proc_data_valid && !pif.proc_start;
    assign capture_en = (state_q == STREAM) || (state_q == WAIT_DONE);

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        lane_window #(.LANE_IDX(k)) u_win (
            .clk             (clk),
            .reset           (reset),
            .start           (pif.proc_start),
            .n               (n_d),
            .seg             (seg_d),
            .ovl             (ovl_d),
            .idx             (idx_q),
            .byte_valid      (byte_valid),
            .capture_en      (capture_en),
            .done_in         (lane_done[k]),
            .match_in        (lane_match[k]),
            .pos_in          (lane_byte_pos[16*k +: 16]),
            .lane_start      (lane_start[k]),
            .lane_num_bytes  (lane_num_bytes[16*k +: 16]),
            .lane_data_valid (lane_data_valid[k]),
            .done_seen       (done_seen_v[k]),
            .match           (match_v[k]),
            .pos             (pos_v[k]),
            .base            (base_v[k])
        );
    end

    // Lowest matching lane wins.
    always_comb begin
        sel_d = '0;
        for (int unsigned k = NUM_LANES; k > 0; k--) begin
            if (match_v[k-1]) sel_d = SEL_W'(k - 1);
        end
    end
    assign any_match = |match_v;

`ifdef PROC_SCHED_TIMEOUT_EN
    logic [15:0] wd_cnt_q;
    assign to_hit = capture_en && (wd_cnt_q == 16'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_cnt_q <= '0;
            timeout  <= 1'b0;
        end else if (pif.proc_start) begin
            wd_cnt_q <= '0;
            timeout  <= 1'b0;
        end else begin
            if (capture_en) wd_cnt_q <= wd_cnt_q + 16'd1;
            if (to_hit)     timeout  <= 1'b1;
        end
    end
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      ;
            STREAM:    if (byte_valid && (idx_q + 17'd1 == n_q)) state_d = WAIT_DONE;
            WAIT_DONE: if (&done_seen_v) state_d = REPORT;
            REPORT:    state_d = HOLD;
            HOLD:      ;
            default:   state_d = IDLE;
        endcase
        if (to_hit) state_d = REPORT;
        if (pif.proc_start) state_d = (n_d == 17'd0) ? WAIT_DONE : STREAM;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            n_q       <= '0;
            idx_q     <= '0;
            lane_data <= '0;
            match_q   <= 1'b0;
            pos_q     <= '0;
            sel_q     <= '0;
        end else if (pif.proc_start) begin
            n_q     <= n_d;
            idx_q   <= '0;
            match_q <= 1'b0;
            pos_q   <= '0;
            sel_q   <= '0;
        end else begin
            if (byte_valid) begin
                lane_data <= pif.proc_data;
                idx_q     <= idx_q + 17'd1;
            end
            // Results are latched on the normal completion path only; a
            // watchdog expiry leaves them at zero.
            if (state_q == WAIT_DONE && &done_seen_v && !to_hit) begin
                match_q <= any_match;
                sel_q   <= sel_d;
                pos_q   <= any_match ? (pos_v[sel_d] + base_v[sel_d]) : '0;
            end
        end
    end

    assign pif.proc_done       = (state_q == REPORT);
    assign pif.proc_match      = match_q;
    assign pif.proc_byte_pos   = pos_q;
    assign pif.proc_match_char = (state_q == HOLD && match_q) ? lane_match_char[8*sel_q +: 8] : 8'd0;
    assign lane_match_char_next = (state_q == HOLD && match_q && pif.proc_match_char_next)
                                  ? (NUM_LANES'(1) << sel_q) : '0;
    assign busy = (state_q == STREAM) || (state_q == WAIT_DONE) || (state_q == REPORT);

endmodule
